// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request/ack handshake, one-entry INST register.
// Handles decoder stall and branch redirect, discarding words from killed fetches.
module fetch_stage #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic [15:0]     INST,
    output logic            inst_valid,
    output logic [PC_W-1:0] inst_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        VALID = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic [PC_W-1:0] pc;

    // Fetch FSM; imem_req and inst_valid are registered alongside the state
    // so they track FETCH/DRAIN and VALID exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_addr  <= RESET_PC;
            imem_req   <= 1'b0;
            INST       <= 16'h0000;
            inst_valid <= 1'b0;
            inst_pc    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (br_taken) begin
                        pc        <= br_target;
                        imem_addr <= br_target;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (imem_ack && !br_taken) begin
                        INST       <= imem_rdata;
                        inst_pc    <= imem_addr;
                        pc         <= imem_addr + PC_ONE;
                        inst_valid <= 1'b1;
                        imem_req   <= 1'b0;
                        state      <= VALID;
                    end else if (imem_ack) begin
                        // word belongs to the killed path; restart at target
                        pc        <= br_target;
                        imem_addr <= br_target;
                    end else if (br_taken) begin
                        // address must stay stable until the old fetch acks
                        pc    <= br_target;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state <= FETCH;
                        if (br_taken) begin
                            pc        <= br_target;
                            imem_addr <= br_target;
                        end else begin
                            imem_addr <= pc;
                        end
                    end else if (br_taken) begin
                        pc <= br_target;
                    end
                end
                VALID: begin
                    if (br_taken) begin
                        inst_valid <= 1'b0;
                        pc         <= br_target;
                        imem_addr  <= br_target;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end else if (!stall) begin
                        inst_valid <= 1'b0;
                        imem_addr  <= pc;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshake, stall, redirects, wrap and reset.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [7:0]  br_target;
    logic [15:0] INST;
    logic        inst_valid;
    logic [7:0]  inst_pc;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .INST       (INST),
        .inst_valid (inst_valid),
        .inst_pc    (inst_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = 8'h00;
        #1;
        chk("rst_req",   32'(imem_req),   32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst",  32'(INST),       32'h0);
        chk("rst_pc",    32'(inst_pc),    32'h0);
        chk("rst_addr",  32'(imem_addr),  32'h0);
        step();
        step();
        rst = 1'b0;

        // first request, one wait cycle, then 1234 returned
        step();
        chk("req_rise", 32'(imem_req),  32'h1);
        chk("req_addr", 32'(imem_addr), 32'h0);
        step();
        chk("wait_req",   32'(imem_req),   32'h1);
        chk("wait_valid", 32'(inst_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        step();
        chk("w0_inst",  32'(INST),       32'h1234);
        chk("w0_valid", 32'(inst_valid), 32'h1);
        chk("w0_pc",    32'(inst_pc),    32'h0);
        chk("w0_req",   32'(imem_req),   32'h0);
        imem_ack = 1'b0;
        step();
        chk("next_addr",  32'(imem_addr),  32'h1);
        chk("next_valid", 32'(inst_valid), 32'h0);

        // zero-wait sequential fetches 1..3
        for (int i = 1; i <= 3; i++) begin
            imem_ack = 1'b1; imem_rdata = 16'hA000 + 16'(i);
            step();
            chk("seq_valid", 32'(inst_valid), 32'h1);
            chk("seq_inst",  32'(INST),       32'hA000 + 32'(i));
            chk("seq_pc",    32'(inst_pc),    32'(i));
            imem_ack = 1'b0;
            step();
            chk("seq_gap",  32'(inst_valid), 32'h0);
            chk("seq_addr", 32'(imem_addr),  32'(i + 1));
        end

        // stall for 3 cycles while holding ABCD; stray ack ignored
        imem_ack = 1'b1; imem_rdata = 16'hABCD; stall = 1'b1;
        step();
        chk("st_inst0", 32'(INST),    32'hABCD);
        chk("st_pc0",   32'(inst_pc), 32'h4);
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin imem_ack = 1'b1; imem_rdata = 16'hFFFF; end
            else imem_ack = 1'b0;
            step();
            chk("st_inst",  32'(INST),       32'hABCD);
            chk("st_pc",    32'(inst_pc),    32'h4);
            chk("st_valid", 32'(inst_valid), 32'h1);
            chk("st_req",   32'(imem_req),   32'h0);
        end
        imem_ack = 1'b0; stall = 1'b0;
        step();
        chk("st_resume_addr", 32'(imem_addr), 32'h5);
        chk("st_resume_req",  32'(imem_req),  32'h1);

        // branch in FETCH at 5, ack late -> drain
        br_taken = 1'b1; br_target = 8'h40;
        step();
        br_taken = 1'b0;
        chk("dr_addr", 32'(imem_addr), 32'h5);
        chk("dr_req",  32'(imem_req),  32'h1);
        step();
        step();
        chk("dr_hold", 32'(imem_addr),  32'h5);
        chk("dr_val",  32'(inst_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        step();
        chk("dr_new_addr", 32'(imem_addr),  32'h40);
        chk("dr_discard",  32'(inst_valid), 32'h0);
        imem_rdata = 16'h4040;
        step();
        chk("br_inst", 32'(INST),       32'h4040);
        chk("br_pc",   32'(inst_pc),    32'h40);
        chk("br_val",  32'(inst_valid), 32'h1);
        imem_ack = 1'b0;
        step();
        chk("br_next", 32'(imem_addr), 32'h41);

        // branch coincident with ack
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        br_taken = 1'b1; br_target = 8'h10;
        step();
        chk("co_valid", 32'(inst_valid), 32'h0);
        chk("co_req",   32'(imem_req),   32'h1);
        chk("co_addr",  32'(imem_addr),  32'h10);
        chk("co_inst",  32'(INST),       32'h4040);
        br_taken = 1'b0; imem_rdata = 16'h1010;
        step();
        chk("co_pc", 32'(inst_pc), 32'h10);
        imem_ack = 1'b0;

        // branch in VALID with stall kills INST
        stall = 1'b1; br_taken = 1'b1; br_target = 8'hFF;
        step();
        chk("vb_valid", 32'(inst_valid), 32'h0);
        chk("vb_addr",  32'(imem_addr),  32'hFF);
        chk("vb_req",   32'(imem_req),   32'h1);
        stall = 1'b0; br_taken = 1'b0;

        // wrap from FF to 00
        imem_ack = 1'b1; imem_rdata = 16'h5A5A;
        step();
        chk("wr_pc",   32'(inst_pc), 32'hFF);
        chk("wr_inst", 32'(INST),    32'h5A5A);
        imem_ack = 1'b0;
        step();
        chk("wr_addr", 32'(imem_addr), 32'h00);

        // drain exit with branch on the ack cycle
        br_taken = 1'b1; br_target = 8'h20;
        step();
        chk("d2_addr", 32'(imem_addr), 32'h00);
        br_target = 8'h30; imem_ack = 1'b1;
        step();
        chk("d2_exit_addr", 32'(imem_addr),  32'h30);
        chk("d2_exit_val",  32'(inst_valid), 32'h0);
        imem_ack = 1'b0;

        // reset asserted in DRAIN, then a stray ack
        br_target = 8'h50;
        step();
        br_taken = 1'b0;
        chk("rd_addr", 32'(imem_addr), 32'h30);
        rst = 1'b1;
        #1;
        chk("rd_req",   32'(imem_req),   32'h0);
        chk("rd_valid", 32'(inst_valid), 32'h0);
        chk("rd_inst",  32'(INST),       32'h0);
        chk("rd_pc",    32'(inst_pc),    32'h0);
        chk("rd_addr0", 32'(imem_addr),  32'h0);
        step();
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h7777;
        step();
        imem_ack = 1'b0;
        chk("late_valid", 32'(inst_valid), 32'h0);
        chk("late_req",   32'(imem_req),   32'h1);
        chk("late_addr",  32'(imem_addr),  32'h0);
        step();
        chk("late_valid2", 32'(inst_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
